// File: rtl/riscv_pkg.sv
// Shared RISC-V constants: base opcodes, sequencer state encoding and the
// opcode classification bundle produced by opcode_class.
package riscv_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4,
    ST_HALT      = 3'd5
  } seq_state_t;

  typedef struct packed {
    logic legal;
    logic is_load;
    logic is_store;
    logic is_branch;
    logic is_system;
  } op_class_t;

endpackage

// File: rtl/multicycle_sequencer_if.sv
// Request/ready handshakes towards the instruction and data memories.
// The sequencer is the master; the memory side is the slave.
interface multicycle_sequencer_if;

  logic imem_req;
  logic imem_ready;
  logic dmem_req;
  logic dmem_we;
  logic dmem_ready;

  modport master (
    output imem_req,
    output dmem_req,
    output dmem_we,
    input  imem_ready,
    input  dmem_ready
  );

  modport slave (
    input  imem_req,
    input  dmem_req,
    input  dmem_we,
    output imem_ready,
    output dmem_ready
  );

endinterface

// File: rtl/multicycle_sequencer_opcode_class.sv
// Combinational opcode classifier. Anything outside the RV32I base opcode
// set comes out with every flag low, including legal.
module opcode_class
  import riscv_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  op_class
);

  // Decode the 7-bit opcode into its class flags.
  always_comb begin
    op_class = '0;
    case (opcode)
      OP_R, OP_I, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: begin
        op_class.legal = 1'b1;
      end
      OP_LOAD: begin
        op_class.legal   = 1'b1;
        op_class.is_load = 1'b1;
      end
      OP_STORE: begin
        op_class.legal    = 1'b1;
        op_class.is_store = 1'b1;
      end
      OP_BRANCH: begin
        op_class.legal     = 1'b1;
        op_class.is_branch = 1'b1;
      end
      OP_SYSTEM: begin
        op_class.legal     = 1'b1;
        op_class.is_system = 1'b1;
      end
      default: begin
        op_class = '0;
      end
    endcase
  end

endmodule

// File: rtl/multicycle_sequencer.sv
// Multi-cycle control sequencer: walks the datapath through
// FETCH/DECODE/EXECUTE/MEM/WRITEBACK, runs the memory handshakes with an
// optional wait timeout, keeps cycle/instret counters and halts on SYSTEM,
// illegal opcodes or a timed-out handshake.
module multicycle_sequencer
  import riscv_pkg::*;
#(
  parameter int CNT_W      = 32,
  parameter int WAIT_LIMIT = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [6:0]               opcode,
  input  logic [2:0]               MemRead,
  input  logic [1:0]               MemWrite,
  input  logic                     RegWrite,
  multicycle_sequencer_if.master   mem,
  output logic                     ir_we,
  output logic                     pc_we,
  output logic                     reg_we,
  output logic                     busy,
  output logic                     halted,
  output logic                     illegal,
  output logic                     bus_err,
  output logic [CNT_W-1:0]         cycle_cnt,
  output logic [CNT_W-1:0]         instret_cnt
);

  localparam int  WAIT_W     = (WAIT_LIMIT > 1) ? $clog2(WAIT_LIMIT + 1) : 1;
  localparam bit  TIMEOUT_EN = (WAIT_LIMIT != 0);
  // Value of the wait counter in the last cycle a missing ready is tolerated.
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((WAIT_LIMIT > 0) ? (WAIT_LIMIT - 1) : 0);

  seq_state_t         state_q, state_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               illegal_q, illegal_d;
  logic               bus_err_q, bus_err_d;
  logic [CNT_W-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0]   instret_cnt_q, instret_cnt_d;
  logic               rst_hold_q, rst_hold_d;

  logic               imem_req_s, dmem_req_s, dmem_we_s;
  logic               ir_we_s, pc_we_s, reg_we_s;
  logic               retire_s;
  logic               mem_access_s;
  logic               quiet_s;
  op_class_t          op_class_s;
  logic               unused_ok_s;

  opcode_class u_opcode_class (
    .opcode   (opcode),
    .op_class (op_class_s)
  );

  // Load/store routing follows the control unit, not the opcode class.
  assign unused_ok_s  = op_class_s.is_load;
  assign mem_access_s = (MemRead != 3'd0) || (MemWrite != 2'd0);

  // Next-state, sticky-flag, wait-counter and raw strobe decode.
  always_comb begin
    state_d    = state_q;
    wait_d     = '0;
    illegal_d  = illegal_q;
    bus_err_d  = bus_err_q;
    retire_s   = 1'b0;
    imem_req_s = 1'b0;
    dmem_req_s = 1'b0;
    dmem_we_s  = 1'b0;
    ir_we_s    = 1'b0;
    pc_we_s    = 1'b0;
    reg_we_s   = 1'b0;
    case (state_q)
      ST_FETCH: begin
        imem_req_s = 1'b1;
        if (mem.imem_ready) begin
          ir_we_s = 1'b1;
          state_d = ST_DECODE;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_DECODE: begin
        if (!op_class_s.legal) begin
          illegal_d = 1'b1;
          state_d   = ST_HALT;
        end else if (op_class_s.is_system) begin
          retire_s = 1'b1;
          state_d  = ST_HALT;
        end else begin
          state_d = ST_EXECUTE;
        end
      end
      ST_EXECUTE: begin
        if (mem_access_s) begin
          state_d = ST_MEM;
        end else begin
          state_d = ST_WRITEBACK;
        end
      end
      ST_MEM: begin
        dmem_req_s = 1'b1;
        dmem_we_s  = (MemWrite != 2'd0);
        if (mem.dmem_ready) begin
          state_d = ST_WRITEBACK;
        end else if (TIMEOUT_EN && (wait_q == WAIT_LAST)) begin
          bus_err_d = 1'b1;
          state_d   = ST_HALT;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WRITEBACK: begin
        pc_we_s  = 1'b1;
        reg_we_s = RegWrite && !op_class_s.is_store && !op_class_s.is_branch;
        retire_s = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_HALT;
      end
    endcase
  end

  // Counter updates; both freeze once HALT is reached.
  always_comb begin
    rst_hold_d = rst;
    if (state_q != ST_HALT) begin
      cycle_cnt_d = cycle_cnt_q + CNT_W'(1);
    end else begin
      cycle_cnt_d = cycle_cnt_q;
    end
    if (retire_s) begin
      instret_cnt_d = instret_cnt_q + CNT_W'(1);
    end else begin
      instret_cnt_d = instret_cnt_q;
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_FETCH;
      wait_q        <= '0;
      illegal_q     <= 1'b0;
      bus_err_q     <= 1'b0;
      cycle_cnt_q   <= '0;
      instret_cnt_q <= '0;
      rst_hold_q    <= 1'b1;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      illegal_q     <= illegal_d;
      bus_err_q     <= bus_err_d;
      cycle_cnt_q   <= cycle_cnt_d;
      instret_cnt_q <= instret_cnt_d;
      rst_hold_q    <= rst_hold_d;
    end
  end

  // Output drive; strobes are silenced from the second cycle of a held reset.
  always_comb begin
    quiet_s      = rst && rst_hold_q;
    mem.imem_req = imem_req_s && !quiet_s;
    mem.dmem_req = dmem_req_s && !quiet_s;
    mem.dmem_we  = dmem_we_s  && !quiet_s;
    ir_we        = ir_we_s    && !quiet_s;
    pc_we        = pc_we_s    && !quiet_s;
    reg_we       = reg_we_s   && !quiet_s;
    busy         = (state_q != ST_HALT) || rst;
    halted       = (state_q == ST_HALT);
    illegal      = illegal_q;
    bus_err      = bus_err_q;
    cycle_cnt    = cycle_cnt_q;
    instret_cnt  = instret_cnt_q;
  end

endmodule
